// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and constants for the custom I/O responder
package io_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GATHER = 2'd1,
      DONE   = 2'd2
   } io_state_e;

   localparam int IO_BYTES_PER_WORD = 4;
   localparam int UART_BYTE_W       = 8;
   localparam int BYTE_IDX_W        = $clog2(IO_BYTES_PER_WORD);

   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(IO_BYTES_PER_WORD - 1);

endpackage

// File: rtl/io_responder_if.sv
// rtl/io_responder_if.sv - pipeline-side and UART-side signal bundle of io_responder
interface io_responder_if
   import io_pkg::*;
#(
   parameter int DATA_W = 32
);
   logic                   in_issued;
   logic                   out_issued;
   logic [DATA_W-1:0]      out_data;
   logic                   io_stall;
   logic [DATA_W-1:0]      in_data;
   logic                   rx_valid;
   logic [UART_BYTE_W-1:0] rx_data;
   logic                   tx_valid;
   logic [UART_BYTE_W-1:0] tx_data;
   logic                   tx_ready;
   logic                   rx_overflow;
   logic [31:0]            rx_byte_count;
   logic [31:0]            tx_byte_count;

   modport master (
      output in_issued, out_issued, out_data, rx_valid, rx_data, tx_ready,
      input  io_stall, in_data, tx_valid, tx_data, rx_overflow, rx_byte_count, tx_byte_count
   );

   modport slave (
      input  in_issued, out_issued, out_data, rx_valid, rx_data, tx_ready,
      output io_stall, in_data, tx_valid, tx_data, rx_overflow, rx_byte_count, tx_byte_count
   );
endinterface

// File: rtl/io_byte_fifo.sv
// rtl/io_byte_fifo.sv - RX byte FIFO; caller qualifies push/pop against full/empty
module io_byte_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   // Extra MSB distinguishes full from empty when the index bits match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/io_responder.sv
// rtl/io_responder.sv - cin_int/out servicing between the pipeline and the UART blocks
// Optional byte counters enabled by defining IO_COUNTERS_EN.
module io_responder
   import io_pkg::*;
#(
   parameter int RX_DEPTH = 16,
   parameter int DATA_W   = 32
) (
   input  logic           clk,
   input  logic           rst,
   io_responder_if.slave  bus
);
   io_state_e              state;
   logic [DATA_W-1:0]      acc;
   logic [BYTE_IDX_W-1:0]  byte_idx;
   logic                   overflow_q;

   logic                   fifo_full;
   logic                   fifo_empty;
   logic [UART_BYTE_W-1:0] fifo_byte;
   logic                   pop;
   logic                   push;
   logic                   out_fire;
   logic                   unused_out_bits;

   assign pop  = ((state == IDLE && bus.in_issued) || state == GATHER) && !fifo_empty;
   // A full FIFO still takes a byte when a pop frees a slot in the same cycle.
   assign push = bus.rx_valid && (!fifo_full || pop);

   io_byte_fifo #(
      .DEPTH (RX_DEPTH),
      .W     (UART_BYTE_W)
   ) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (bus.rx_data),
      .pop       (pop),
      .pop_data  (fifo_byte),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         acc        <= '0;
         byte_idx   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (bus.rx_valid && !push) overflow_q <= 1'b1;
         if (pop) begin
            acc[{byte_idx, 3'b000} +: UART_BYTE_W] <= fifo_byte;
            byte_idx <= byte_idx + 1'b1;
         end
         case (state)
            IDLE:    if (bus.in_issued) state <= GATHER;
            GATHER:  if (pop && byte_idx == LAST_BYTE_IDX) state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // IN has priority if both requests show up together.
   assign bus.tx_valid = bus.out_issued && !bus.in_issued && state == IDLE;
   assign bus.tx_data  = bus.out_data[UART_BYTE_W-1:0];
   assign out_fire     = bus.tx_valid && bus.tx_ready;

   assign bus.io_stall = (state == IDLE && bus.in_issued) || state == GATHER ||
                         (bus.out_issued && !bus.in_issued && !out_fire);
   assign bus.in_data     = acc;
   assign bus.rx_overflow = overflow_q;

   assign unused_out_bits = ^bus.out_data[DATA_W-1:UART_BYTE_W];

`ifdef IO_COUNTERS_EN
   logic [31:0] rx_cnt;
   logic [31:0] tx_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_cnt <= '0;
         tx_cnt <= '0;
      end else begin
         if (push)     rx_cnt <= rx_cnt + 32'd1;
         if (out_fire) tx_cnt <= tx_cnt + 32'd1;
      end
   end

   assign bus.rx_byte_count = rx_cnt;
   assign bus.tx_byte_count = tx_cnt;
`else
   assign bus.rx_byte_count = '0;
   assign bus.tx_byte_count = '0;
`endif

   a_in_out_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(bus.in_issued && bus.out_issued));
endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - directed self-checking bench for io_responder
module tb_io_responder;
   import io_pkg::*;

`ifdef IO_COUNTERS_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_asserts = 0;
   int   n_fail = 0;
   int   tx_seen = 0;
   int   cyc;

   io_responder_if #(.DATA_W(32)) bus ();

   io_responder #(.RX_DEPTH(16), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.tx_valid && bus.tx_ready) tx_seen++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_release(output int n);
      n = 0;
      #1;
      while (bus.io_stall !== 1'b0 && n < 100) begin
         tick();
         #1;
         n++;
      end
   endtask

   // Issues cin_int, optionally pushing one byte in its first cycle, and checks word and latency.
   task automatic gather(input string tag, input logic [31:0] exp, input int exp_cyc,
                         input bit side_push, input logic [7:0] side_byte);
      int n;
      bus.in_issued = 1'b1;
      bus.rx_valid  = side_push;
      bus.rx_data   = side_byte;
      #1;
      n = 0;
      while (bus.io_stall !== 1'b0 && n < 100) begin
         tick();
         bus.rx_valid = 1'b0;
         #1;
         n++;
      end
      chk({tag, "_cycles"}, n, exp_cyc);
      chk({tag, "_data"}, bus.in_data, exp);
      tick();
      bus.in_issued = 1'b0;
      bus.rx_valid  = 1'b0;
   endtask

   initial begin
      bus.in_issued  = 1'b0;
      bus.out_issued = 1'b0;
      bus.out_data   = '0;
      bus.rx_valid   = 1'b0;
      bus.rx_data    = '0;
      bus.tx_ready   = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_stall", bus.io_stall, 0);
      chk("rst_in_data", bus.in_data, 0);
      chk("rst_tx_valid", bus.tx_valid, 0);
      chk("rst_tx_data", bus.tx_data, 0);
      chk("rst_overflow", bus.rx_overflow, 0);
      chk("rst_rx_cnt", bus.rx_byte_count, 0);
      chk("rst_tx_cnt", bus.tx_byte_count, 0);
      rst = 1'b0;

      // 1: reset after two pops discards the partial word and the queued bytes
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      bus.in_issued = 1'b1;
      #1 chk("t1_stall_idle", bus.io_stall, 1);
      tick();
      #1 chk("t1_stall_g1", bus.io_stall, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.in_issued = 1'b0;
      #1 chk("t1_stall_after_rst", bus.io_stall, 0);
      chk("t1_acc_cleared", bus.in_data, 0);
      bus.in_issued = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t1_wait_empty", bus.io_stall, 1);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = 8'hA1 + 8'(i);
         #1 chk("t1_wait_push", bus.io_stall, 1);
         tick();
      end
      bus.rx_valid = 1'b0;
      wait_release(cyc);
      chk("t1_release_cycles", cyc, 1);
      chk("t1_word", bus.in_data, 32'hA4A3A2A1);
      tick();
      bus.in_issued = 1'b0;

      // 2: four bytes queued -> four stall cycles then the little-endian word
      push_byte(8'h78); push_byte(8'h56); push_byte(8'h34); push_byte(8'h12);
      bus.in_issued = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("t2_stall", bus.io_stall, 1);
         tick();
      end
      #1 chk("t2_release", bus.io_stall, 0);
      chk("t2_word", bus.in_data, 32'h12345678);
      tick();
      bus.in_issued = 1'b0;
      #1 chk("t2_idle", bus.io_stall, 0);

      // 3: empty FIFO, bytes trickle in every 10 cycles
      bus.in_issued = 1'b1;
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 9; c++) begin
            #1 chk("t3_hold", bus.io_stall, 1);
            tick();
         end
         bus.rx_valid = 1'b1;
         bus.rx_data  = (k == 0) ? 8'hEF : (k == 1) ? 8'hBE : (k == 2) ? 8'hAD : 8'hDE;
         #1 chk("t3_hold_push", bus.io_stall, 1);
         tick();
         bus.rx_valid = 1'b0;
      end
      #1 chk("t3_last_pop_stall", bus.io_stall, 1);
      tick();
      #1 chk("t3_release", bus.io_stall, 0);
      chk("t3_word", bus.in_data, 32'hDEADBEEF);
      tick();
      bus.in_issued = 1'b0;

      // 4: out with tx_ready low for three cycles, then a zero-latency out
      bus.out_issued = 1'b1;
      bus.out_data   = 32'hDEADBEEF;
      bus.tx_ready   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t4_stall", bus.io_stall, 1);
         chk("t4_tx_valid", bus.tx_valid, 1);
         chk("t4_tx_data", bus.tx_data, 32'hEF);
         tick();
      end
      bus.tx_ready = 1'b1;
      #1 chk("t4_release", bus.io_stall, 0);
      chk("t4_tx_data_fire", bus.tx_data, 32'hEF);
      tick();
      bus.out_issued = 1'b0;
      bus.tx_ready   = 1'b0;
      #1 chk("t4_once", tx_seen, 1);
      chk("t4_tx_cnt", bus.tx_byte_count, CNT_EN ? 32'd1 : 32'd0);
      bus.out_issued = 1'b1;
      bus.out_data   = 32'h1234565A;
      bus.tx_ready   = 1'b1;
      #1 chk("t4_zero_lat_stall", bus.io_stall, 0);
      chk("t4_zero_lat_data", bus.tx_data, 32'h5A);
      tick();
      bus.out_issued = 1'b0;
      bus.tx_ready   = 1'b0;
      #1 chk("t4_twice", tx_seen, 2);
      chk("t4_idle_tx_valid", bus.tx_valid, 0);

      // 5: seventeen pushes into a 16-deep FIFO
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      #1 chk("t5_no_ovf_at_16", bus.rx_overflow, 0);
      push_byte(8'h10);
      #1 chk("t5_ovf", bus.rx_overflow, 1);
      chk("t5_rx_cnt", bus.rx_byte_count, CNT_EN ? 32'd16 : 32'd0);
      tick();
      #1 chk("t5_ovf_sticky", bus.rx_overflow, 1);

      // 6: push coincident with a pop while full; nothing lost, no overflow
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
      gather("t6_w0", 32'h23222120, 4, 1'b1, 8'h30);
      chk("t6_no_ovf", bus.rx_overflow, 0);
      chk("t6_rx_cnt", bus.rx_byte_count, CNT_EN ? 32'd17 : 32'd0);
      gather("t6_w1", 32'h27262524, 4, 1'b0, 8'h00);
      gather("t6_w2", 32'h2B2A2928, 4, 1'b0, 8'h00);
      gather("t6_w3", 32'h2F2E2D2C, 4, 1'b0, 8'h00);
      push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
      gather("t6_w4", 32'h33323130, 4, 1'b0, 8'h00);
      chk("t6_no_ovf_end", bus.rx_overflow, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
